// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM state encodings and the serial byte width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        FEED_IDLE      = 2'b00,
        FEED_REQ       = 2'b01,
        FEED_WAIT_DONE = 2'b10
    } feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with wrap-around pointers, a separate occupancy counter and full/empty flags.
// The head entry is presented combinationally on rd_data.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                level <= level + (AW + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                level <= level - (AW + 1)'(1);
            end
        end
    end

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign rd_data = mem[rptr];

endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// Queues producer bytes and launches them one at a time into the UART transmitter.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow flag (ovf / ovf_clr).
module uart_tx_fifo_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            level,
    output logic                   tx_start,
    output logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_active,
    input  logic                   tx_done,
    output logic                   busy
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                   ovf,
    input  logic                   ovf_clr
`endif
);

    feed_state_t            state;
    feed_state_t            state_nxt;
    logic [UART_DATA_W-1:0] head;
    logic                   pop;

    // Never launch while the transmitter is still busy, e.g. finishing a frame across our reset.
    assign pop = (state == FEED_IDLE) && !empty && !tx_active;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FEED_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= '0;
        end else if (pop) begin
            tx_data <= head;
        end
    end

    // tx_start stays high through REQ until the transmitter reports it has latched the byte.
    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        case (state)
            FEED_IDLE: begin
                if (pop) begin
                    state_nxt = FEED_REQ;
                end
            end
            FEED_REQ: begin
                tx_start = 1'b1;
                if (tx_active) begin
                    state_nxt = FEED_WAIT_DONE;
                end
            end
            FEED_WAIT_DONE: begin
                if (tx_done) begin
                    state_nxt = FEED_IDLE;
                end
            end
            default: begin
                state_nxt = FEED_IDLE;
            end
        endcase
    end

    assign busy = (state != FEED_IDLE);

`ifdef UART_TX_FIFO_OVF_EN
    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (wr_en && full && !pop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Bench for uart_tx_fifo_feeder paired with a behavioural UART transmitter at 4 clocks per bit.
module tb_uart_tx_fifo_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;
    logic       busy;
`ifdef UART_TX_FIFO_OVF_EN
    logic       ovf;
    logic       ovf_clr = 1'b0;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_feeder #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .busy      (busy)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`endif
    );

    // Transmitter model: start bit, 8 data bits LSB first, stop bit, 4 clocks each; no reset.
    logic       line = 1'b1;
    logic [9:0] frame = 10'h3FF;
    logic [3:0] bit_idx = 4'd0;
    logic [1:0] clk_cnt = 2'd0;
    logic [7:0] sent_q[$];

    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (!tx_active) begin
            if (tx_start) begin
                tx_active <= 1'b1;
                frame     <= {1'b1, tx_data, 1'b0};
                line      <= 1'b0;
                bit_idx   <= 4'd0;
                clk_cnt   <= 2'd0;
                sent_q.push_back(tx_data);
            end
        end else if (clk_cnt == 2'd3) begin
            clk_cnt <= 2'd0;
            if (bit_idx == 4'd9) begin
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
                line      <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                line    <= frame[bit_idx + 4'd1];
            end
        end else begin
            clk_cnt <= clk_cnt + 2'd1;
        end
    end

    // Monitor: done-to-start gap and launches issued while the transmitter is active.
    int   cyc = 0;
    int   last_done_cyc = -1;
    int   max_gap = 0;
    int   bad_launch = 0;
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tx_done) last_done_cyc = cyc;
        if (tx_start && !prev_start) begin
            if (tx_active) bad_launch = bad_launch + 1;
            if (last_done_cyc >= 0 && (cyc - last_done_cyc) > max_gap) max_gap = cyc - last_done_cyc;
        end
        prev_start = tx_start;
    end

    task automatic push_byte(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_active(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_active) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sent_q.size() == n && !busy && !tx_active && empty) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        cmp_cnt++; if (full !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
        cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        cmp_cnt++; if (level !== 4'd0) begin err_cnt++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        cmp_cnt++; if (tx_start !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start); end
        cmp_cnt++; if (tx_data !== 8'h00) begin err_cnt++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
`ifdef UART_TX_FIFO_OVF_EN
        cmp_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [9:0] exp_line;
        bit         ok;
        exp_line = 10'b1_10100101_0;
        sent_q.delete();
        push_byte(8'hA5);
        cmp_cnt++; if (level !== 4'd1) begin err_cnt++; $display("[TB] FAIL single_level_push: got %0d expected 1", level); end
        cmp_cnt++; if (empty !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_empty_push: got %b expected 0", empty); end
        cmp_cnt++; if (tx_start !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_start_early: got %b expected 0", tx_start); end
        @(negedge clk);
        cmp_cnt++; if (tx_start !== 1'b1) begin err_cnt++; $display("[TB] FAIL single_start: got %b expected 1", tx_start); end
        cmp_cnt++; if (tx_data !== 8'hA5) begin err_cnt++; $display("[TB] FAIL single_tx_data: got %h expected a5", tx_data); end
        cmp_cnt++; if (level !== 4'd0) begin err_cnt++; $display("[TB] FAIL single_level_pop: got %0d expected 0", level); end
        repeat (2) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            cmp_cnt++; if (line !== exp_line[b]) begin err_cnt++; $display("[TB] FAIL single_line_bit%0d: got %b expected %b", b, line, exp_line[b]); end
            cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("[TB] FAIL single_empty_frame%0d: got %b expected 1", b, empty); end
            if (b < 9) repeat (4) @(negedge clk);
        end
        wait_done(ok);
        cmp_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("[TB] FAIL single_done_timeout: got %b expected 1", ok); end
        cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("[TB] FAIL single_busy_at_done: got %b expected 1", busy); end
        @(negedge clk);
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL single_busy_after_done: got %b expected 0", busy); end
        cmp_cnt++; if (sent_q.size() != 1) begin err_cnt++; $display("[TB] FAIL single_frames: got %0d expected 1", sent_q.size()); end
    endtask

    task automatic test_burst();
        bit ok;
        sent_q.delete();
        last_done_cyc = -1;
        max_gap = 0;
        for (int i = 0; i < 8; i++) push_byte(8'(i + 1));
        // The first byte is launched on the second push cycle, so seven remain queued.
        cmp_cnt++; if (level !== 4'd7) begin err_cnt++; $display("[TB] FAIL burst_level: got %0d expected 7", level); end
        cmp_cnt++; if (full !== 1'b0) begin err_cnt++; $display("[TB] FAIL burst_full: got %b expected 0", full); end
        wait_drain(8, ok);
        cmp_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("[TB] FAIL burst_drain_timeout: got %b expected 1", ok); end
        for (int i = 0; i < 8; i++) begin
            cmp_cnt++; if (sent_q[i] !== 8'(i + 1)) begin err_cnt++; $display("[TB] FAIL burst_byte%0d: got %h expected %h", i, sent_q[i], 8'(i + 1)); end
        end
        cmp_cnt++; if (max_gap < 1 || max_gap > 3) begin err_cnt++; $display("[TB] FAIL burst_gap: got %0d expected 1..3", max_gap); end
        cmp_cnt++; if (level !== 4'd0) begin err_cnt++; $display("[TB] FAIL burst_level_end: got %0d expected 0", level); end
    endtask

    task automatic test_overflow();
        bit ok;
        sent_q.delete();
        push_byte(8'h10);
        wait_active(ok);
        cmp_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("[TB] FAIL ovf_active_timeout: got %b expected 1", ok); end
        for (int i = 0; i < 8; i++) push_byte(8'(8'h11 + i));
        cmp_cnt++; if (level !== 4'd8) begin err_cnt++; $display("[TB] FAIL ovf_level_fill: got %0d expected 8", level); end
        cmp_cnt++; if (full !== 1'b1) begin err_cnt++; $display("[TB] FAIL ovf_full: got %b expected 1", full); end
        push_byte(8'hFF);
        cmp_cnt++; if (level !== 4'd8) begin err_cnt++; $display("[TB] FAIL ovf_level_drop: got %0d expected 8", level); end
`ifdef UART_TX_FIFO_OVF_EN
        cmp_cnt++; if (ovf !== 1'b1) begin err_cnt++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf); end
        repeat (3) @(negedge clk);
        cmp_cnt++; if (ovf !== 1'b1) begin err_cnt++; $display("[TB] FAIL ovf_sticky: got %b expected 1", ovf); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        cmp_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("[TB] FAIL ovf_clear: got %b expected 0", ovf); end
`endif
        wait_drain(9, ok);
        cmp_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("[TB] FAIL ovf_drain_timeout: got %b expected 1", ok); end
        for (int i = 0; i < 8; i++) begin
            cmp_cnt++; if (sent_q[i + 1] !== 8'(8'h11 + i)) begin err_cnt++; $display("[TB] FAIL ovf_byte%0d: got %h expected %h", i + 1, sent_q[i + 1], 8'(8'h11 + i)); end
        end
    endtask

    task automatic test_push_pop_full();
        bit ok;
        sent_q.delete();
        push_byte(8'h20);
        wait_active(ok);
        for (int i = 0; i < 8; i++) push_byte(8'(8'h21 + i));
        wait_done(ok);
        cmp_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("[TB] FAIL ppf_done_timeout: got %b expected 1", ok); end
        @(negedge clk);
        cmp_cnt++; if (busy !== 1'b0 || level !== 4'd8) begin err_cnt++; $display("[TB] FAIL ppf_idle_full: got busy=%b level=%0d expected busy=0 level=8", busy, level); end
        push_byte(8'h77);
        cmp_cnt++; if (level !== 4'd8) begin err_cnt++; $display("[TB] FAIL ppf_level: got %0d expected 8", level); end
        cmp_cnt++; if (tx_start !== 1'b1 || tx_data !== 8'h21) begin err_cnt++; $display("[TB] FAIL ppf_launch: got start=%b data=%h expected start=1 data=21", tx_start, tx_data); end
        wait_drain(10, ok);
        cmp_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("[TB] FAIL ppf_drain_timeout: got %b expected 1", ok); end
        cmp_cnt++; if (sent_q[8] !== 8'h28) begin err_cnt++; $display("[TB] FAIL ppf_byte8: got %h expected 28", sent_q[8]); end
        cmp_cnt++; if (sent_q[9] !== 8'h77) begin err_cnt++; $display("[TB] FAIL ppf_last: got %h expected 77", sent_q[9]); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        sent_q.delete();
        bad_launch = 0;
        push_byte(8'h30);
        wait_active(ok);
        for (int i = 0; i < 3; i++) push_byte(8'(8'h31 + i));
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_active && bit_idx == 4'd4) begin
                ok = 1'b1;
                break;
            end
        end
        cmp_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("[TB] FAIL rmf_bit3_timeout: got %b expected 1", ok); end
        rst_n = 1'b0;
        #1;
        cmp_cnt++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin err_cnt++; $display("[TB] FAIL rmf_fifo_reset: got level=%0d empty=%b full=%b expected 0/1/0", level, empty, full); end
        cmp_cnt++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL rmf_fsm_reset: got start=%b data=%h busy=%b expected 0/00/0", tx_start, tx_data, busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(ok);
        cmp_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("[TB] FAIL rmf_frame_finish: got %b expected 1", ok); end
        repeat (5) @(negedge clk);
        cmp_cnt++; if (sent_q.size() != 1 || tx_start !== 1'b0) begin err_cnt++; $display("[TB] FAIL rmf_no_relaunch: got frames=%0d start=%b expected 1/0", sent_q.size(), tx_start); end
        push_byte(8'h3C);
        wait_drain(2, ok);
        cmp_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("[TB] FAIL rmf_drain_timeout: got %b expected 1", ok); end
        cmp_cnt++; if (sent_q[1] !== 8'h3C) begin err_cnt++; $display("[TB] FAIL rmf_post_byte: got %h expected 3c", sent_q[1]); end
        cmp_cnt++; if (bad_launch != 0) begin err_cnt++; $display("[TB] FAIL rmf_launch_while_active: got %0d expected 0", bad_launch); end
    endtask

    task automatic test_wrap();
        bit ok;
        bit all_ok;
        sent_q.delete();
        all_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_byte(8'(8'h40 + i));
            wait_drain(i + 1, ok);
            if (!ok) all_ok = 1'b0;
        end
        cmp_cnt++; if (all_ok !== 1'b1) begin err_cnt++; $display("[TB] FAIL wrap_drain_timeout: got %b expected 1", all_ok); end
        cmp_cnt++; if (sent_q.size() != 20) begin err_cnt++; $display("[TB] FAIL wrap_count: got %0d expected 20", sent_q.size()); end
        for (int i = 0; i < 20; i++) begin
            cmp_cnt++; if (sent_q[i] !== 8'(8'h40 + i)) begin err_cnt++; $display("[TB] FAIL wrap_byte%0d: got %h expected %h", i, sent_q[i], 8'(8'h40 + i)); end
        end
    endtask

    initial begin
        $display("[TB] starting uart_tx_fifo_feeder bench");
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
